// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- pipeline-to-hazard-controller bundle.
//
// Carries the register numbers and timing tags that the pipeline registers
// expose to the hazard controller. The bundle also carries the stall,
// md_busy and forwarding-select outputs back to the datapath. No data
// values pass through it.
//
// Modports:
//   master : pipeline side (drives register numbers/tags, receives selects)
//   slave  : hazard controller side
interface hazard_ctrl_if;
  // D stage
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_Tuse_rs;
  logic [1:0] D_Tuse_rt;
  logic       D_is_md;
  // E stage
  logic [4:0] E_rs;
  logic [4:0] E_rt;
  logic [4:0] E_A3;
  logic [1:0] E_Tnew;
  logic       E_md_start;
  logic       E_md_isdiv;
  // M stage
  logic [4:0] M_A3;
  logic [1:0] M_Tnew;
  logic [4:0] M_rt;
  // W stage
  logic [4:0] W_A3;
  // controller outputs
  logic       stall;
  logic       md_busy;
  logic [1:0] D_rs_sel;
  logic [1:0] D_rt_sel;
  logic [1:0] E_rs_sel;
  logic [1:0] E_rt_sel;
  logic       M_ForwardStoreDataMux_Sel;

  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
    output E_rs, E_rt, E_A3, E_Tnew, E_md_start, E_md_isdiv,
    output M_A3, M_Tnew, M_rt, W_A3,
    input  stall, md_busy, D_rs_sel, D_rt_sel, E_rs_sel, E_rt_sel,
    input  M_ForwardStoreDataMux_Sel
  );

  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
    input  E_rs, E_rt, E_A3, E_Tnew, E_md_start, E_md_isdiv,
    input  M_A3, M_Tnew, M_rt, W_A3,
    output stall, md_busy, D_rs_sel, D_rt_sel, E_rs_sel, E_rt_sel,
    output M_ForwardStoreDataMux_Sel
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- central hazard controller for the five-stage pipeline.
//
// This module decides D-stage stalls from Tuse/Tnew comparisons and from the
// multiply/divide busy counter. It also drives every forwarding-mux select.
// It sees only register numbers and timing tags.
//
// Ports:
//   clk   : pipeline clock
//   reset : synchronous, active-high reset
//   hz    : hazard_ctrl_if.slave bundle. It carries the D/E/M/W register
//           numbers, Tuse/Tnew tags and mult/div start to this module. It
//           returns stall, md_busy, the D/E operand selects and the M-stage
//           store-data select.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {IDLE, BUSY} mdState_t;

  mdState_t   state;
  mdState_t   nextState;
  logic [3:0] count;
  logic [3:0] nextCount;
  logic [3:0] loadVal;

  // A stage only forwards/blocks a real destination; $0 is never a producer.
  function automatic logic hits(input logic [4:0] a3, input logic [4:0] r);
    return (r != 5'd0) && (a3 == r);
  endfunction

  // D operands: the E result is the youngest, so it beats M. W needs no path
  // because the register file writes through to its read ports.
  function automatic logic [1:0] dSel(input logic [4:0] r,
                                      input logic [4:0] eA3, input logic [1:0] eTnew,
                                      input logic [4:0] mA3, input logic [1:0] mTnew);
    if (hits(eA3, r) && (eTnew == 2'd0))      return 2'd1;
    else if (hits(mA3, r) && (mTnew == 2'd0)) return 2'd2;
    else                                      return 2'd0;
  endfunction

  function automatic logic [1:0] eSel(input logic [4:0] r,
                                      input logic [4:0] mA3, input logic [1:0] mTnew,
                                      input logic [4:0] wA3);
    if (hits(mA3, r) && (mTnew == 2'd0)) return 2'd1;
    else if (hits(wA3, r))               return 2'd2;
    else                                 return 2'd0;
  endfunction

  // Tuse = 3 (unused operand) can never be below a Tnew of at most 2, so it
  // never stalls without a dedicated term.
  logic dataStall;
  logic mdStall;

  assign dataStall = (hits(hz.E_A3, hz.D_rs) && (hz.D_Tuse_rs < hz.E_Tnew)) ||
                     (hits(hz.M_A3, hz.D_rs) && (hz.D_Tuse_rs < hz.M_Tnew)) ||
                     (hits(hz.E_A3, hz.D_rt) && (hz.D_Tuse_rt < hz.E_Tnew)) ||
                     (hits(hz.M_A3, hz.D_rt) && (hz.D_Tuse_rt < hz.M_Tnew));

  // The start cycle itself must stall too: md_busy only rises one edge later.
  assign mdStall = hz.D_is_md && (hz.E_md_start || hz.md_busy);

  assign hz.stall    = dataStall || mdStall;
  assign hz.md_busy  = (count != 4'd0);
  assign hz.D_rs_sel = dSel(hz.D_rs, hz.E_A3, hz.E_Tnew, hz.M_A3, hz.M_Tnew);
  assign hz.D_rt_sel = dSel(hz.D_rt, hz.E_A3, hz.E_Tnew, hz.M_A3, hz.M_Tnew);
  assign hz.E_rs_sel = eSel(hz.E_rs, hz.M_A3, hz.M_Tnew, hz.W_A3);
  assign hz.E_rt_sel = eSel(hz.E_rt, hz.M_A3, hz.M_Tnew, hz.W_A3);
  assign hz.M_ForwardStoreDataMux_Sel = hits(hz.W_A3, hz.M_rt);

  assign loadVal = hz.E_md_isdiv ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    nextState = state;
    nextCount = count;
    unique case (state)
      IDLE: begin
        if (hz.E_md_start) begin
          nextCount = loadVal;
          nextState = (loadVal != 4'd0) ? BUSY : IDLE;
        end
      end
      BUSY: begin
        // A start while busy is normally blocked by stall. If it happens
        // anyway, the latest start wins and the count reloads.
        if (hz.E_md_start) begin
          nextCount = loadVal;
          nextState = (loadVal != 4'd0) ? BUSY : IDLE;
        end else begin
          nextCount = count - 4'd1;
          if (count == 4'd1) nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
        nextCount = 4'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= nextState;
      count <= nextCount;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
//
// The reference model computes the outputs straight from the pipeline rules.
// Busy tracking is done as "last busy cycle" arithmetic on a cycle index.
// One compare process checks every output on every negative edge. Directed
// sequences add literal expectations, and a randomized phase follows them.
module tb_hazard_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  hazard_ctrl_if hzIf ();

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hzIf)
  );

  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;
  int cyc       = 0;
  int busyEnd   = -1;
  bit checkEn   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit hit(input logic [4:0] a3, input logic [4:0] r);
    return (r != 0) && (a3 == r);
  endfunction

  function automatic bit modelBusy();
    return cyc <= busyEnd;
  endfunction

  function automatic bit operandStalls(input logic [4:0] r, input logic [1:0] tuse);
    int u;
    u = int'(tuse);
    if (u == 3) return 1'b0;
    return (hit(hzIf.E_A3, r) && u < int'(hzIf.E_Tnew)) ||
           (hit(hzIf.M_A3, r) && u < int'(hzIf.M_Tnew));
  endfunction

  function automatic bit modelStall();
    return operandStalls(hzIf.D_rs, hzIf.D_Tuse_rs) ||
           operandStalls(hzIf.D_rt, hzIf.D_Tuse_rt) ||
           (hzIf.D_is_md && (hzIf.E_md_start || modelBusy()));
  endfunction

  function automatic logic [1:0] modelDSel(input logic [4:0] r);
    if (hit(hzIf.E_A3, r) && hzIf.E_Tnew == 0) return 2'd1;
    if (hit(hzIf.M_A3, r) && hzIf.M_Tnew == 0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] modelESel(input logic [4:0] r);
    if (hit(hzIf.M_A3, r) && hzIf.M_Tnew == 0) return 2'd1;
    if (hit(hzIf.W_A3, r)) return 2'd2;
    return 2'd0;
  endfunction

  // Busy window bookkeeping. A start in cycle c keeps the unit busy through
  // c+N. Reset makes the current cycle the last busy one.
  always @(posedge clk) begin
    if (reset)                busyEnd = cyc;
    else if (hzIf.E_md_start) busyEnd = cyc + (hzIf.E_md_isdiv ? DIV_N : MULT_N);
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (checkEn) begin
      check("stall",    32'(hzIf.stall),    32'(modelStall()));
      check("md_busy",  32'(hzIf.md_busy),  32'(modelBusy()));
      check("D_rs_sel", 32'(hzIf.D_rs_sel), 32'(modelDSel(hzIf.D_rs)));
      check("D_rt_sel", 32'(hzIf.D_rt_sel), 32'(modelDSel(hzIf.D_rt)));
      check("E_rs_sel", 32'(hzIf.E_rs_sel), 32'(modelESel(hzIf.E_rs)));
      check("E_rt_sel", 32'(hzIf.E_rt_sel), 32'(modelESel(hzIf.E_rt)));
      check("st_sel",   32'(hzIf.M_ForwardStoreDataMux_Sel), 32'(hit(hzIf.W_A3, hzIf.M_rt)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    hzIf.D_rs = 0; hzIf.D_rt = 0; hzIf.D_Tuse_rs = 2'd3; hzIf.D_Tuse_rt = 2'd3;
    hzIf.D_is_md = 0; hzIf.E_rs = 0; hzIf.E_rt = 0; hzIf.E_A3 = 0; hzIf.E_Tnew = 0;
    hzIf.E_md_start = 0; hzIf.E_md_isdiv = 0; hzIf.M_A3 = 0; hzIf.M_Tnew = 0;
    hzIf.M_rt = 0; hzIf.W_A3 = 0;
  endtask

  task automatic runMd(input bit isDiv, input int n, input string tag);
    clearInputs();
    hzIf.D_is_md = 1; hzIf.E_md_start = 1; hzIf.E_md_isdiv = isDiv;
    @(negedge clk);
    check({tag, "_stall_c0"}, 32'(hzIf.stall), 32'd1);
    check({tag, "_busy_c0"},  32'(hzIf.md_busy), 32'd0);
    for (int k = 1; k <= n + 1; k++) begin
      nextCycle();
      hzIf.E_md_start = 0;
      @(negedge clk);
      check({tag, "_busy"},  32'(hzIf.md_busy), 32'(k <= n));
      check({tag, "_stall"}, 32'(hzIf.stall),   32'(k <= n));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    clearInputs();
    reset = 1;
    nextCycle();
    checkEn = 1'b1;
    @(negedge clk);
    check("reset_busy",  32'(hzIf.md_busy), 32'd0);
    check("reset_stall", 32'(hzIf.stall),   32'd0);

    // Load-use: the load sits in E with its result two cycles out.
    nextCycle(); reset = 0;
    hzIf.E_A3 = 8; hzIf.E_Tnew = 2; hzIf.D_rs = 8; hzIf.D_Tuse_rs = 1;
    @(negedge clk);
    check("loaduse_E", 32'(hzIf.stall), 32'd1);
    // Load now in M with Tnew 1. An E-stage consumer (Tuse 1) is satisfied,
    // but a D-stage consumer (Tuse 0) still waits.
    nextCycle();
    hzIf.E_A3 = 0; hzIf.M_A3 = 8; hzIf.M_Tnew = 1;
    @(negedge clk);
    check("loaduse_M_tuse1", 32'(hzIf.stall), 32'd0);
    nextCycle(); hzIf.D_Tuse_rs = 0;
    @(negedge clk);
    check("loaduse_M_tuse0", 32'(hzIf.stall), 32'd1);
    // Load in W, consumer in E.
    nextCycle();
    clearInputs(); hzIf.W_A3 = 8; hzIf.E_rs = 8;
    @(negedge clk);
    check("loaduse_W_stall", 32'(hzIf.stall),    32'd0);
    check("loaduse_W_esel",  32'(hzIf.E_rs_sel), 32'd2);

    // Branch forward from M, then E takes priority.
    nextCycle();
    clearInputs(); hzIf.M_A3 = 9; hzIf.M_Tnew = 0; hzIf.D_rt = 9; hzIf.D_Tuse_rt = 0;
    @(negedge clk);
    check("branch_stall", 32'(hzIf.stall),    32'd0);
    check("branch_M",     32'(hzIf.D_rt_sel), 32'd2);
    nextCycle(); hzIf.E_A3 = 9; hzIf.E_Tnew = 0;
    @(negedge clk);
    check("branch_E_prio", 32'(hzIf.D_rt_sel), 32'd1);

    // Store data forwarding, and $0 never matches.
    nextCycle();
    clearInputs(); hzIf.M_rt = 5; hzIf.W_A3 = 5;
    @(negedge clk);
    check("store_fwd", 32'(hzIf.M_ForwardStoreDataMux_Sel), 32'd1);
    nextCycle(); hzIf.M_rt = 0; hzIf.W_A3 = 0; hzIf.E_rs = 0; hzIf.D_rs = 0;
    hzIf.D_Tuse_rs = 0; hzIf.E_Tnew = 2; hzIf.M_A3 = 0; hzIf.E_A3 = 0;
    @(negedge clk);
    check("store_r0",  32'(hzIf.M_ForwardStoreDataMux_Sel), 32'd0);
    check("r0_stall",  32'(hzIf.stall),    32'd0);
    check("r0_esel",   32'(hzIf.E_rs_sel), 32'd0);

    // Busy windows.
    nextCycle(); runMd(1'b1, DIV_N,  "div");
    nextCycle(); runMd(1'b0, MULT_N, "mult");

    // Reset in the middle of a divide.
    nextCycle();
    clearInputs(); hzIf.D_is_md = 1; hzIf.E_md_start = 1; hzIf.E_md_isdiv = 1;
    nextCycle(); hzIf.E_md_start = 0;
    nextCycle();
    nextCycle(); reset = 1;
    @(negedge clk);
    check("rst_mid_busy_c3", 32'(hzIf.md_busy), 32'd1);
    nextCycle(); reset = 0;
    @(negedge clk);
    check("rst_mid_busy_c4",  32'(hzIf.md_busy), 32'd0);
    check("rst_mid_stall_c4", 32'(hzIf.stall),   32'd0);

    // A non-md instruction flows past a busy unit.
    nextCycle();
    clearInputs(); hzIf.E_md_start = 1;
    nextCycle(); hzIf.E_md_start = 0;
    @(negedge clk);
    check("nonmd_busy",  32'(hzIf.md_busy), 32'd1);
    check("nonmd_stall", 32'(hzIf.stall),   32'd0);
    repeat (MULT_N) nextCycle();

    // Randomized phase: small register range for frequent hits, rare starts
    // and resets. The compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      reset           = ($urandom_range(0, 63) == 0);
      hzIf.D_rs       = 5'($urandom_range(0, 3));
      hzIf.D_rt       = 5'($urandom_range(0, 3));
      hzIf.D_Tuse_rs  = 2'($urandom_range(0, 3));
      hzIf.D_Tuse_rt  = 2'($urandom_range(0, 3));
      hzIf.D_is_md    = 1'($urandom_range(0, 1));
      hzIf.E_rs       = 5'($urandom_range(0, 3));
      hzIf.E_rt       = 5'($urandom_range(0, 3));
      hzIf.E_A3       = 5'($urandom_range(0, 3));
      hzIf.E_Tnew     = 2'($urandom_range(0, 2));
      hzIf.M_A3       = 5'($urandom_range(0, 3));
      hzIf.M_Tnew     = 2'($urandom_range(0, 1));
      hzIf.M_rt       = 5'($urandom_range(0, 3));
      hzIf.W_A3       = 5'($urandom_range(0, 3));
      hzIf.E_md_start = ($urandom_range(0, 11) == 0);
      hzIf.E_md_isdiv = 1'($urandom_range(0, 1));
    end

    nextCycle();
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
